// File: rtl/digit_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scan_mux_pkg
//  Purpose  : Shared types, constants and helpers for the multiplexed
//             digit scanner (state encoding, blank value, index search).
//  Revision : 1.0 - initial release
// ============================================================================
package digit_scan_mux_pkg;

  // Scanner operating states
  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_MANUAL = 2'd2
  } state_e;

  // Value driven on OUT while the display is blanked
  localparam int BLANK_VAL = 0;

  // Default prescaler division (clock cycles per scan slot)
  localparam int DEFAULT_REFRESH_DIV = 100000;

  // Channel index space is fixed at 3 bits, i.e. up to 8 channels
  localparam int MAX_CH = 8;
  localparam int IDX_W  = 3;

  // Result of the next-enabled-channel search
  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } search_t;

  // Mode/enable decode: manual overrides everything, an empty mask blanks
  function automatic state_e classify(input logic mode, input logic any_enabled);
    state_e st;
    if (mode) begin
      st = ST_MANUAL;
    end else if (!any_enabled) begin
      st = ST_BLANK;
    end else begin
      st = ST_SCAN;
    end
    return st;
  endfunction

  // First enabled channel strictly after 'cur', wrapping modulo num_ch.
  // The candidate offset runs 1..num_ch, so with a single enabled channel
  // the search lands back on 'cur' itself. Loop bound is a constant.
  function automatic search_t next_enabled(input logic [MAX_CH-1:0] mask,
                                           input logic [IDX_W-1:0]  cur,
                                           input int                num_ch);
    search_t r;
    int      cand;
    r.found = 1'b0;
    r.idx   = cur;
    for (int k = 1; k <= MAX_CH; k++) begin
      cand = int'(cur) + k;
      if (cand >= num_ch) begin
        cand = cand - num_ch;
      end
      if (!r.found && (k <= num_ch) && mask[cand[IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/digit_scan_mux_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tick_gen
//  Purpose  : Free-running prescaler. Counts 0..DIV-1 and wraps; TICK is
//             high for the single cycle in which the count sits at DIV-1.
//  Revision : 1.0 - initial release
// ============================================================================
module tick_gen
  import digit_scan_mux_pkg::*;
#(
  parameter int DIV = DEFAULT_REFRESH_DIV,
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  output logic             TICK,
  output logic [CNT_W-1:0] COUNT
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: wrap to zero after the terminal value
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign TICK  = (count_q == LAST);
  assign COUNT = count_q;

endmodule
`default_nettype wire

// File: rtl/digit_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : digit_scan_mux
//  Purpose  : Time-multiplexed channel scanner for multi-digit displays.
//             Auto-scans enabled channels, supports manual selection and
//             blanking; output data always comes from a per-frame snapshot
//             so a frame never mixes old and new input values.
//  Revision : 1.0 - initial release
// ============================================================================
module digit_scan_mux
  import digit_scan_mux_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 4,
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [NUM_CH*DATA_W-1:0] IN,
  input  logic [NUM_CH-1:0]        EN_MASK,
  input  logic                     MODE,
  input  logic [2:0]               MAN_SEL,
  output logic [DATA_W-1:0]        OUT,
  output logic [NUM_CH-1:0]        ANODE_N,
  output logic [2:0]               CH_IDX,
  output logic                     STROBE,
  output logic                     FRAME
);

  localparam int PRESCALE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DATA_W-1:0] BLANK_DATA = DATA_W'(BLANK_VAL);

  // Prescaler
  logic                  tick;
  logic [PRESCALE_W-1:0] prescale_cnt_unused;

  tick_gen #(
    .DIV (REFRESH_DIV)
  ) u_tick_gen (
    .CLK    (CLK),
    .RESETN (RESETN),
    .TICK   (tick),
    .COUNT  (prescale_cnt_unused)
  );

  // State and registered control. The mode/mask/select inputs are sampled
  // every cycle together with the state so that the state and the mask
  // used by the index search always describe the same instant.
  state_e                   state_q,   state_d;
  logic [NUM_CH-1:0]        mask_q,    mask_d;
  logic [2:0]               man_sel_q, man_sel_d;
  logic [NUM_CH*DATA_W-1:0] shadow_q,  shadow_d;
  logic [DATA_W-1:0]        out_q,     out_d;
  logic [NUM_CH-1:0]        anode_n_q, anode_n_d;
  logic [2:0]               idx_q,     idx_d;
  logic                     strobe_q,  strobe_d;
  logic                     frame_q,   frame_d;

  logic [MAX_CH-1:0] mask_ext;
  search_t           srch;
  logic              man_valid;

  // Zero-extend the sampled mask to the fixed search width
  always_comb begin
    mask_ext               = '0;
    mask_ext[NUM_CH-1:0]   = mask_q;
  end

  // Next enabled channel after the displayed one
  always_comb begin
    srch = next_enabled(mask_ext, idx_q, NUM_CH);
  end

  // Manual selection is only displayable inside the channel range
  always_comb begin
    man_valid = (int'(man_sel_q) < NUM_CH);
  end

  // Next-state and output decode; display outputs only move on TICK
  always_comb begin
    state_d   = classify(MODE, |EN_MASK);
    mask_d    = EN_MASK;
    man_sel_d = MAN_SEL;
    shadow_d  = shadow_q;
    out_d     = out_q;
    anode_n_d = anode_n_q;
    idx_d     = idx_q;
    strobe_d  = 1'b0;
    frame_d   = 1'b0;

    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          strobe_d = 1'b1;
          if (srch.found) begin
            idx_d     = srch.idx;
            anode_n_d = ~(NUM_CH'(1) << srch.idx);
            // A non-increasing index means the scan wrapped: start a new
            // frame. The fresh snapshot equals IN on this edge, so the
            // displayed value is taken from IN directly.
            if (srch.idx <= idx_q) begin
              shadow_d = IN;
              frame_d  = 1'b1;
              out_d    = IN[int'(srch.idx)*DATA_W +: DATA_W];
            end else begin
              out_d    = shadow_q[int'(srch.idx)*DATA_W +: DATA_W];
            end
          end else begin
            out_d     = BLANK_DATA;
            anode_n_d = '1;
          end
        end

        ST_MANUAL: begin
          strobe_d = 1'b1;
          frame_d  = 1'b1;
          shadow_d = IN;
          if (man_valid) begin
            idx_d     = man_sel_q;
            anode_n_d = ~(NUM_CH'(1) << man_sel_q);
            out_d     = IN[int'(man_sel_q)*DATA_W +: DATA_W];
          end else begin
            out_d     = BLANK_DATA;
            anode_n_d = '1;
          end
        end

        ST_BLANK: begin
          out_d     = BLANK_DATA;
          anode_n_d = '1;
        end

        default: begin
          out_d     = BLANK_DATA;
          anode_n_d = '1;
        end
      endcase
    end
  end

  // All scanner state, cleared asynchronously
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= ST_SCAN;
      mask_q    <= '0;
      man_sel_q <= '0;
      shadow_q  <= '0;
      out_q     <= BLANK_DATA;
      anode_n_q <= '1;
      idx_q     <= '0;
      strobe_q  <= 1'b0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      man_sel_q <= man_sel_d;
      shadow_q  <= shadow_d;
      out_q     <= out_d;
      anode_n_q <= anode_n_d;
      idx_q     <= idx_d;
      strobe_q  <= strobe_d;
      frame_q   <= frame_d;
    end
  end

  assign OUT     = out_q;
  assign ANODE_N = anode_n_q;
  assign CH_IDX  = idx_q;
  assign STROBE  = strobe_q;
  assign FRAME   = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_digit_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_digit_scan_mux
//  Purpose  : Self-checking bench for digit_scan_mux with a behavioural
//             reference model, directed scenarios and a randomized phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_digit_scan_mux;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int DIV = 4;

  logic           CLK    = 1'b0;
  logic           RESETN = 1'b1;
  logic [N*W-1:0] IN     = '0;
  logic [N-1:0]   EN_MASK = '0;
  logic           MODE   = 1'b0;
  logic [2:0]     MAN_SEL = '0;
  logic [W-1:0]   OUT;
  logic [N-1:0]   ANODE_N;
  logic [2:0]     CH_IDX;
  logic           STROBE;
  logic           FRAME;

  int checks = 0;
  int errors = 0;

  digit_scan_mux #(
    .NUM_CH      (N),
    .DATA_W      (W),
    .REFRESH_DIV (DIV)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .IN      (IN),
    .EN_MASK (EN_MASK),
    .MODE    (MODE),
    .MAN_SEL (MAN_SEL),
    .OUT     (OUT),
    .ANODE_N (ANODE_N),
    .CH_IDX  (CH_IDX),
    .STROBE  (STROBE),
    .FRAME   (FRAME)
  );

  always #5 CLK = ~CLK;

  // Reference model: slot counter, displayed channel, frame snapshot
  int           m_cnt;
  int           m_idx;
  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_out;
  logic [N-1:0] m_anode;
  logic         m_strobe;
  logic         m_frame;
  // Control as seen at the previous clock edge
  logic         p_mode;
  logic [N-1:0] p_mask;
  logic [2:0]   p_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_idx = 0;
    for (int k = 0; k < N; k++) m_shadow[k] = '0;
    m_out    = '0;
    m_anode  = '1;
    m_strobe = 1'b0;
    m_frame  = 1'b0;
    p_mode   = 1'b0;
    p_mask   = '0;
    p_sel    = '0;
  endtask

  task automatic show_channel(input int ch);
    m_idx = ch;
    m_out = m_shadow[ch];
    for (int k = 0; k < N; k++) m_anode[k] = (k != ch);
  endtask

  task automatic take_snapshot();
    for (int k = 0; k < N; k++) m_shadow[k] = IN[k*W +: W];
    m_frame = 1'b1;
  endtask

  task automatic model_edge();
    bit tick;
    int nxt;
    if (!RESETN) begin
      model_reset();
      return;
    end
    tick     = (m_cnt == DIV - 1);
    m_cnt    = tick ? 0 : m_cnt + 1;
    m_strobe = 1'b0;
    m_frame  = 1'b0;
    if (tick) begin
      if (p_mode) begin
        m_strobe = 1'b1;
        take_snapshot();
        if (p_sel < N) show_channel(int'(p_sel));
        else begin m_out = '0; m_anode = '1; end
      end else if (p_mask == '0) begin
        m_out   = '0;
        m_anode = '1;
      end else begin
        m_strobe = 1'b1;
        nxt = m_idx;
        for (int k = 1; k <= N; k++) begin
          if (p_mask[(m_idx + k) % N]) begin
            nxt = (m_idx + k) % N;
            break;
          end
        end
        if (nxt <= m_idx) take_snapshot();
        show_channel(nxt);
      end
    end
    p_mode = MODE;
    p_mask = EN_MASK;
    p_sel  = MAN_SEL;
  endtask

  // One clock: advance the model on the edge, compare 1 time unit later
  task automatic cycle();
    @(posedge CLK);
    model_edge();
    #1;
    chk("out",     OUT,     m_out);
    chk("anode_n", ANODE_N, m_anode);
    chk("ch_idx",  CH_IDX,  m_idx);
    chk("strobe",  STROBE,  m_strobe);
    chk("frame",   FRAME,   m_frame);
  endtask

  task automatic wait_strobe(input int max_cyc, output int n);
    n = 0;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      n++;
      if (STROBE === 1'b1) break;
    end
    chk("strobe_seen", STROBE, 1);
  endtask

  task automatic apply_reset();
    RESETN = 1'b0;
    model_reset();
    #1;
    chk("rst_out",    OUT,     0);
    chk("rst_anode",  ANODE_N, 4'hF);
    chk("rst_idx",    CH_IDX,  0);
    chk("rst_strobe", STROBE,  0);
    chk("rst_frame",  FRAME,   0);
    repeat (2) cycle();
  endtask

  initial begin
    int n;
    logic [N-1:0] exp_an;
    model_reset();
    IN      = 16'h4321;
    EN_MASK = 4'hF;
    MODE    = 1'b0;
    MAN_SEL = 3'd0;
    #2;
    apply_reset();
    RESETN = 1'b1;

    // First slot after reset: first frame still shows the cleared snapshot
    wait_strobe(10, n);
    chk("first_strobe_lat", n, 4);
    chk("first_idx", CH_IDX, 1);
    chk("pre_frame_out", OUT, 0);
    wait_strobe(10, n);
    wait_strobe(10, n);
    wait_strobe(10, n);
    chk("wrap_frame", FRAME, 1);
    chk("wrap_idx", CH_IDX, 0);
    chk("wrap_out", OUT, 1);
    chk("wrap_anode", ANODE_N, 4'b1110);
    for (int k = 1; k < N; k++) begin
      wait_strobe(10, n);
      exp_an = 4'b1111 ^ (4'b0001 << k);
      chk("scan_period", n, 4);
      chk("scan_out", OUT, k + 1);
      chk("scan_anode", ANODE_N, exp_an);
      chk("scan_noframe", FRAME, 0);
    end

    // Tear-free snapshot
    wait_strobe(10, n);
    wait_strobe(10, n);
    chk("tear_pre_ch1", OUT, 2);
    IN = 16'h8765;
    wait_strobe(10, n);
    chk("tear_ch2", OUT, 3);
    wait_strobe(10, n);
    chk("tear_ch3", OUT, 4);
    for (int k = 0; k < N; k++) begin
      wait_strobe(10, n);
      chk("new_frame_out", OUT, 5 + k);
      chk("new_frame_flag", FRAME, (k == 0) ? 1 : 0);
    end

    // Skip disabled channels
    IN      = 16'h4321;
    EN_MASK = 4'b1010;
    for (int r = 0; r < 4; r++) begin
      wait_strobe(10, n);
      chk("skip_idx",   CH_IDX, (r % 2 == 0) ? 1 : 3);
      chk("skip_out",   OUT,    (r % 2 == 0) ? 2 : 4);
      chk("skip_frame", FRAME,  (r % 2 == 0) ? 1 : 0);
    end

    // Manual select
    MODE    = 1'b1;
    MAN_SEL = 3'd2;
    wait_strobe(10, n);
    chk("man_out",   OUT,     3);
    chk("man_anode", ANODE_N, 4'b1011);
    chk("man_idx",   CH_IDX,  2);
    chk("man_frame", FRAME,   1);

    // Blank
    MODE    = 1'b0;
    EN_MASK = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("blank_strobe", STROBE, 0);
    end
    chk("blank_out",   OUT,     0);
    chk("blank_anode", ANODE_N, 4'hF);
    chk("blank_idx",   CH_IDX,  2);
    EN_MASK = 4'b0001;
    wait_strobe(12, n);
    chk("unblank_idx",   CH_IDX,  0);
    chk("unblank_frame", FRAME,   1);
    chk("unblank_out",   OUT,     1);
    chk("unblank_anode", ANODE_N, 4'b1110);

    // Manual with out-of-range select
    MODE    = 1'b1;
    MAN_SEL = 3'd5;
    wait_strobe(10, n);
    chk("maninv_out",   OUT,     0);
    chk("maninv_anode", ANODE_N, 4'hF);
    chk("maninv_idx",   CH_IDX,  0);

    // Reset mid-scan
    MODE    = 1'b0;
    EN_MASK = 4'hF;
    cycle();
    cycle();
    apply_reset();
    RESETN = 1'b1;
    wait_strobe(10, n);
    chk("rst2_strobe_lat", n, 4);
    chk("rst2_idx", CH_IDX, 1);

    // Randomized phase against the model
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) IN = (N*W)'($urandom());
      if ($urandom_range(0, 9) == 0) EN_MASK = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom());
      if ($urandom_range(0, 11) == 0) MODE = ~MODE;
      if ($urandom_range(0, 7) == 0) MAN_SEL = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        apply_reset();
        RESETN = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/digit_scan_mux.md
DIGIT_SCAN_MUX -- requirements
Module: digit_scan_mux

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, meaning the number of input channels (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning the width of each channel in bits.
REQ-003 The block SHALL have parameter REFRESH_DIV, default 100000, meaning CLK cycles per scan slot (>=2).
REQ-004 The block SHALL have port CLK, input, 1 bit, the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port RESETN, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-006 The block SHALL have port IN, input, NUM_CH*DATA_W bits, with channel k at bits [k*DATA_W +: DATA_W].
REQ-007 The block SHALL have port EN_MASK, input, NUM_CH bits; bit k=1 includes channel k in the scan.
REQ-008 The block SHALL have port MODE, input, 1 bit: 0 = auto scan, 1 = manual select.
REQ-009 The block SHALL have port MAN_SEL, input, 3 bits, the manual channel index.
REQ-010 The block SHALL have port OUT, output, DATA_W bits, the registered selected channel data.
REQ-011 The block SHALL have port ANODE_N, output, NUM_CH bits, an active-low one-hot select of the displayed channel.
REQ-012 The block SHALL have port CH_IDX, output, 3 bits, the index of the displayed channel.
REQ-013 The block SHALL have port STROBE, output, 1 bit, a one-cycle pulse when the displayed channel is updated.
REQ-014 The block SHALL have port FRAME, output, 1 bit, a one-cycle pulse when the input snapshot is refreshed.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1, wrap to 0, and assert internal TICK for one cycle at count REFRESH_DIV-1.
REQ-016 The FSM SHALL have exactly three states: SCAN, BLANK and MANUAL.
REQ-017 The FSM SHALL evaluate MODE and EN_MASK every cycle: MODE=1 selects MANUAL; otherwise EN_MASK==0 selects BLANK; otherwise SCAN.
REQ-018 In SCAN, on TICK the index SHALL advance to the next enabled channel in ascending order, wrapping NUM_CH-1 to 0, and skipping disabled channels.
REQ-019 In SCAN, if the current index is disabled at TICK, the block SHALL select the next enabled channel above it, modulo NUM_CH.
REQ-020 In SCAN, when the advance wraps (new index <= old index, including a single enabled channel), the block SHALL copy IN into a shadow register and pulse FRAME on the same edge.
REQ-021 OUT SHALL always be taken from the shadow register, never directly from IN, so that no frame tears.
REQ-022 In MANUAL, on each TICK the block SHALL set index = MAN_SEL, refresh the shadow, and pulse FRAME; EN_MASK SHALL be ignored.
REQ-023 If MAN_SEL >= NUM_CH in MANUAL, the block SHALL blank the output.
REQ-024 When blanked (state BLANK or an invalid MAN_SEL), on TICK the block SHALL drive OUT=0, ANODE_N all ones and leave CH_IDX unchanged.
REQ-025 On a TICK that updates the display, OUT, ANODE_N, CH_IDX and STROBE SHALL all update on that TICK edge, i.e. one cycle after the prescaler reaches REFRESH_DIV-1.
REQ-026 STROBE SHALL pulse on every TICK edge in SCAN and MANUAL, and SHALL stay 0 in BLANK.
REQ-027 A MODE change between ticks SHALL NOT change any output before the next TICK.
REQ-028 The prescaler SHALL run freely and SHALL NOT reset on a MODE change.

Reset
REQ-029 While RESETN=0, the block SHALL hold prescaler=0, index=0, shadow=0, OUT=0, ANODE_N all ones, CH_IDX=0, STROBE=0, FRAME=0 and state=SCAN.
REQ-030 On the first cycle after RESETN rises, the prescaler SHALL start from 0, and the first TICK SHALL occur REFRESH_DIV cycles later.
REQ-031 Reset asserted mid-slot SHALL clear all state immediately, with no pending STROBE or FRAME.

Structure
REQ-032 The shared package SHALL hold the state encoding (SCAN, BLANK, MANUAL), the BLANK_VAL=0 constant and the default REFRESH_DIV.
REQ-033 The prescaler SHALL be a sub-module named tick_gen, parameterised by DIV, with outputs TICK and the counter value.
REQ-034 The next-enabled-index search SHALL be purely combinational and bounded by NUM_CH.

Verification
Bench settings for all scenarios: NUM_CH=4, DATA_W=4, REFRESH_DIV=4.
REQ-035 Auto scan: IN=0x4321, EN_MASK=1111, MODE=0 -> OUT cycles 1,2,3,4; ANODE_N cycles 1110,1101,1011,0111; STROBE every 4 cycles; FRAME at each wrap to index 0.
REQ-036 Skip: EN_MASK=1010 -> CH_IDX alternates 1,3; OUT alternates 2,4; FRAME pulses each time the index goes 3 -> 1.
REQ-037 Tear-free: change IN to 0x8765 while on channel 1 -> channels 2 and 3 still show 3,4; the next frame shows 5,6,7,8.
REQ-038 Manual: MODE=1, MAN_SEL=2 -> after the next TICK, OUT=3, ANODE_N=1011, CH_IDX=2; MAN_SEL=5 -> OUT=0, ANODE_N=1111.
REQ-039 Blank: EN_MASK=0000 -> after the next TICK, OUT=0, ANODE_N=1111, STROBE stays 0; restoring EN_MASK=0001 -> the next TICK shows channel 0 with FRAME=1.
REQ-040 Reset: RESETN pulled low mid-scan -> all outputs are at reset values within the same cycle; after release, the first STROBE occurs 4 cycles later with CH_IDX=1.
